// File: rtl/segmem_arbiter_if.sv
// segmem_arbiter_if
// Bundles the two requester ports and the single-port memory bus that the
// segmented-memory arbiter sits between.
//
// Handshake (both requester ports): a requester raises reqN with weN/addrN/wdN
// and holds all four stable until it sees gntN. gntN is a one-cycle accept
// pulse. Exactly one cycle after gntN, rvalidN pulses once, with errN and rdata
// qualified by it. Dropping reqN before gntN withdraws the request. Every
// access completes through rvalidN, including writes and rejected accesses.
//
// Signals:
//   req0/req1, we0/we1, addr0/addr1, wd0/wd1 : requester -> arbiter
//   gnt0/gnt1, rvalid0/rvalid1, err0/err1     : arbiter -> requester
//   rdata                                     : arbiter -> requester (shared)
//   mem_a, mem_wd, mem_we                     : arbiter -> memory
//   mem_rd                                    : memory -> arbiter (1-cycle latency)
//
// Modports: slave = arbiter view, master = environment view.
interface segmem_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wd0;
  logic [DW-1:0] wd1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic          err0;
  logic          err1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic          mem_we;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd,
    output gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata,
           mem_a, mem_wd, mem_we
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd,
    input  gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata,
           mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/segmem_arbiter.sv
// segmem_arbiter
// Shares the single address/write/read port of the segmented memory
// (instruction ROM 0..IMEM_TOP, RAM and image buffers up to MEM_TOP) between
// the CPU data port (port 0) and the image streamer (port 1). One access is
// in flight at a time: IDLE -> ISSUE (gnt, memory driven) -> RESP (rvalid).
// Writes into the instruction segment and any address above MEM_TOP are
// rejected: the memory is never written, and the access completes with err.
// Port 0 wins by default; after STARVE_LIMIT consecutive contended port-0
// grants, port 1 is forced.
//
// Ports:
//   clk        : sole clock, rising edge
//   reset      : asynchronous, active-high
//   bus        : requester and memory signals (segmem_arbiter_if.slave)
//   state_dbg  : current FSM state (0 IDLE, 1 ISSUE, 2 RESP)
//   starve_dbg : current starvation counter
module segmem_arbiter #(
  parameter int DW           = 32,
  parameter int AW           = 32,
  parameter int IMEM_TOP     = 299,
  parameter int MEM_TOP      = 45399,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  segmem_arbiter_if.slave                     bus,
  output logic [1:0]                          state_dbg,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]   starve_dbg
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW-1:0] IMEM_TOP_A = AW'(IMEM_TOP);
  localparam logic [AW-1:0] MEM_TOP_A  = AW'(MEM_TOP);
  localparam logic [SW-1:0] LIMIT      = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [SW-1:0] starve_cnt, starve_next;

  logic          any_req;
  logic          arb_point;
  logic          pick1;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wd;
  logic          win_legal;

  // Attributes of the access in flight, captured at arbitration.
  logic          cur_port;
  logic          cur_legal;
  logic          cur_read;

  // Arbitration, legality decode, next state and next starve count.
  always_comb begin
    any_req     = bus.req0 | bus.req1;
    arb_point   = (state == IDLE) || (state == RESP);
    pick1       = bus.req1 && (!bus.req0 || (starve_cnt == LIMIT));
    win_we      = pick1 ? bus.we1   : bus.we0;
    win_addr    = pick1 ? bus.addr1 : bus.addr0;
    win_wd      = pick1 ? bus.wd1   : bus.wd0;
    win_legal   = !(win_addr > MEM_TOP_A) && !(win_we && (win_addr <= IMEM_TOP_A));
    state_next  = state;
    starve_next = starve_cnt;

    case (state)
      IDLE:    state_next = any_req ? ISSUE : IDLE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = any_req ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase

    // The counter only moves where a decision could be made. With req1 high,
    // pick1 == 0 implies port 0 won against a waiting port 1.
    if (arb_point) begin
      if (!bus.req1 || pick1) begin
        starve_next = '0;
      end else if (starve_cnt != LIMIT) begin
        starve_next = starve_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Registered outputs. Pulses default low each cycle; the asynchronous reset
  // drops mem_we immediately, so an in-flight write is abandoned before the
  // memory can sample it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      bus.err0    <= 1'b0;
      bus.err1    <= 1'b0;
      bus.mem_a   <= '0;
      bus.mem_wd  <= '0;
      bus.mem_we  <= 1'b0;
      cur_port    <= 1'b0;
      cur_legal   <= 1'b0;
      cur_read    <= 1'b0;
    end else begin
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      bus.err0    <= 1'b0;
      bus.err1    <= 1'b0;
      bus.mem_we  <= 1'b0;

      if (arb_point && any_req) begin
        cur_port   <= pick1;
        cur_legal  <= win_legal;
        cur_read   <= !win_we && win_legal;
        bus.gnt0   <= !pick1;
        bus.gnt1   <= pick1;
        bus.mem_a  <= win_addr;
        bus.mem_wd <= win_wd;
        bus.mem_we <= win_we && win_legal;
      end

      if (state == ISSUE) begin
        bus.rvalid0 <= !cur_port;
        bus.rvalid1 <= cur_port;
        bus.err0    <= !cur_port && !cur_legal;
        bus.err1    <= cur_port && !cur_legal;
      end
    end
  end

  // The memory read data is already registered, so it is passed straight
  // through during RESP of a legal read; everything else returns zero.
  assign bus.rdata  = ((state == RESP) && cur_read) ? bus.mem_rd : '0;
  assign state_dbg  = state;
  assign starve_dbg = starve_cnt;

endmodule

// File: tb/tb_segmem_arbiter.sv
// tb_segmem_arbiter
// Directed bench for segmem_arbiter with a behavioural single-port memory
// (registered read, one-cycle latency) preloaded with 0x1000_0000 + address.
module tb_segmem_arbiter;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int MEM_TOP = 45399;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  logic [2:0] starve_dbg;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:MEM_TOP];

  int exp_g [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int exp_s [10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
  logic [31:0] exp_b2b [3] = '{32'h1234_5678, 32'h1000_012D, 32'h1000_012E};

  segmem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  segmem_arbiter #(
    .DW(DW), .AW(AW), .IMEM_TOP(299), .MEM_TOP(MEM_TOP), .STARVE_LIMIT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .state_dbg  (state_dbg),
    .starve_dbg (starve_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory model ----------------
  initial begin
    for (int i = 0; i <= MEM_TOP; i++) mem[i] = 32'h1000_0000 + i;
  end

  always @(posedge clk) begin
    if (bus.mem_a <= MEM_TOP) begin
      bus.mem_rd <= mem[bus.mem_a[15:0]];
      if (bus.mem_we) mem[bus.mem_a[15:0]] = bus.mem_wd;
    end else begin
      bus.mem_rd <= '0;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_req(input int p, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wd0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wd1 = d;
    end
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 0) ? bus.gnt0 : bus.gnt1;
  endfunction

  // One complete access from an idle arbiter; sampling on negedges.
  task automatic access(input string tag, input int p, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_mwe, input logic exp_err,
                        input logic [31:0] exp_rd);
    int n;
    n = 0;
    @(negedge clk);
    set_req(p, 1'b1, w, a, d);
    do begin
      @(negedge clk);
      n++;
    end while (!gnt_of(p) && n < 8);
    check({tag, ".gnt_latency"}, n, 1);
    check({tag, ".mem_we"}, bus.mem_we, exp_mwe);
    check({tag, ".mem_a"}, bus.mem_a, a);
    if (w) check({tag, ".mem_wd"}, bus.mem_wd, d);
    set_req(p, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check({tag, ".rvalid"}, (p == 0) ? bus.rvalid0 : bus.rvalid1, 1'b1);
    check({tag, ".rvalid_other"}, (p == 0) ? bus.rvalid1 : bus.rvalid0, 1'b0);
    check({tag, ".err"}, (p == 0) ? bus.err0 : bus.err1, exp_err);
    check({tag, ".rdata"}, bus.rdata, exp_rd);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".gnt"}, {bus.gnt1, bus.gnt0}, 0);
    check({tag, ".rvalid"}, {bus.rvalid1, bus.rvalid0}, 0);
    check({tag, ".err"}, {bus.err1, bus.err0}, 0);
    check({tag, ".mem_we"}, bus.mem_we, 0);
    check({tag, ".rdata"}, bus.rdata, 0);
    check({tag, ".state"}, state_dbg, 0);
    check({tag, ".starve"}, starve_dbg, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check_quiet("in_reset");
    check("in_reset.mem_a", bus.mem_a, 0);
    reset = 1'b0;
    @(negedge clk);
    check_quiet("after_reset");

    // Single write then read-back on the streamer port.
    access("wr400", 1, 1'b1, 400, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    access("rd400", 1, 1'b0, 400, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);

    // Protection and range boundaries.
    access("wr299", 0, 1'b1, 299, 32'hBAD0_0001, 1'b0, 1'b1, 32'h0);
    access("wr300", 0, 1'b1, 300, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
    access("rd45400", 0, 1'b0, 45400, 32'h0, 1'b0, 1'b1, 32'h0);
    access("rd45399", 0, 1'b0, 45399, 32'h0, 1'b0, 1'b0, 32'h1000_B157);
    access("rd0", 0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 32'h1000_0000);
    access("rd299", 0, 1'b0, 299, 32'h0, 1'b0, 1'b0, 32'h1000_012B);

    // Contention: both held high continuously.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 301, '0);
    set_req(1, 1'b1, 1'b0, 302, '0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("cont%0d.state_issue", k), state_dbg, 1);
      check($sformatf("cont%0d.gnt1", k), bus.gnt1, exp_g[k]);
      check($sformatf("cont%0d.gnt0", k), bus.gnt0, (exp_g[k] == 0) ? 1 : 0);
      check($sformatf("cont%0d.starve", k), starve_dbg, exp_s[k]);
      @(negedge clk);
      check($sformatf("cont%0d.state_resp", k), state_dbg, 2);
      check($sformatf("cont%0d.rvalid1", k), bus.rvalid1, exp_g[k]);
      check($sformatf("cont%0d.rvalid0", k), bus.rvalid0, (exp_g[k] == 0) ? 1 : 0);
      check($sformatf("cont%0d.rdata", k), bus.rdata,
            (exp_g[k] == 1) ? 32'h1000_012E : 32'h1000_012D);
      if (k == 9) begin
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
      end
    end
    @(negedge clk);
    check_quiet("cont_end");

    // Withdrawal: req1 pulsed only during port 0's ISSUE.
    set_req(0, 1'b1, 1'b0, 303, '0);
    @(negedge clk);
    check("wd.gnt0", bus.gnt0, 1);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b0, 304, '0);
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, '0, '0);
    check("wd.rvalid0", bus.rvalid0, 1);
    check("wd.rdata", bus.rdata, 32'h1000_012F);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_quiet($sformatf("wd_after%0d", k));
    end

    // Back-to-back reads on port 0: ISSUE/RESP alternate without IDLE.
    set_req(0, 1'b1, 1'b0, 300, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("b2b%0d.state_issue", k), state_dbg, 1);
      check($sformatf("b2b%0d.gnt0", k), bus.gnt0, 1);
      check($sformatf("b2b%0d.mem_a", k), bus.mem_a, 300 + k);
      if (k < 2) set_req(0, 1'b1, 1'b0, 301 + k, '0);
      else set_req(0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check($sformatf("b2b%0d.state_resp", k), state_dbg, 2);
      check($sformatf("b2b%0d.rvalid0", k), bus.rvalid0, 1);
      check($sformatf("b2b%0d.rdata", k), bus.rdata, exp_b2b[k]);
    end
    @(negedge clk);
    check_quiet("b2b_end");

    // Reset in the middle of ISSUE of a legal write.
    set_req(1, 1'b1, 1'b1, 401, 32'hCAFE_F00D);
    @(negedge clk);
    check("rst.gnt1", bus.gnt1, 1);
    check("rst.mem_we_before", bus.mem_we, 1);
    set_req(1, 1'b0, 1'b0, '0, '0);
    #2 reset = 1'b1;
    #1;
    check("rst.mem_we_async", bus.mem_we, 0);
    check("rst.state_async", state_dbg, 0);
    check("rst.gnt1_async", bus.gnt1, 0);
    @(negedge clk);
    check("rst.no_rvalid", bus.rvalid1, 0);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_quiet($sformatf("rst_after%0d", k));
      check($sformatf("rst_after%0d.mem_a", k), bus.mem_a, 0);
    end
    // The abandoned write must not have reached memory.
    access("rd401", 1, 1'b0, 401, 32'h0, 1'b0, 1'b0, 32'h1000_0191);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
